frame_write_controller: RTL and testbench

FRAME_WRITE_CONTROLLER -- requirements
Module: frame_write_controller

---
 rtl/frame_write_controller.sv | 130 +++++++++++++
 tb/tb_frame_write_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_controller.sv
// Frame write controller: stores a raster-scanned RGB frame into SRAM at
// row*W+col, checks line-end framing, and hands the frame to the readout side.
module frame_write_controller #(
  parameter int W = 256,
  parameter int H = 256
) (
  input  logic        Clk_in,
  input  logic        Reset_n,
  input  logic        in_pixel_ready,
  input  logic        in_pixel_valid,
  input  logic        in_line_end,
  input  logic [23:0] in_pixel_data,
  input  logic        read_finish,
  output logic        SRAM_EN_w,
  output logic        SRAM_WE_w,
  output logic [19:0] SRAM_Addr_w,
  output logic [23:0] SRAM_Din,
  output logic        write_finish,
  output logic        frame_error
);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DONE, W_ERR} state_t;

  localparam logic [8:0]  COL_LAST = 9'(W - 1);
  localparam logic [8:0]  ROW_LAST = 9'(H - 1);
  localparam logic [19:0] LINE_W   = 20'(W);

  state_t      state_q, state_d;
  logic [8:0]  col_i_q, col_i_d;
  logic [8:0]  row_i_q, row_i_d;
  logic        wr_q, wr_d;
  logic [19:0] addr_q, addr_d;
  logic [23:0] din_q, din_d;
  logic        write_finish_q, write_finish_d;
  logic        frame_error_q, frame_error_d;

  logic        sof;
  logic        at_last_col;
  logic        at_origin;
  logic        line_end_bad;
  logic [19:0] pix_addr;

  assign sof          = in_pixel_valid & in_pixel_ready;
  assign at_last_col  = (col_i_q == COL_LAST);
  assign at_origin    = (col_i_q == 9'd0) && (row_i_q == 9'd0);
  assign line_end_bad = (in_line_end != at_last_col);
  assign pix_addr     = 20'(row_i_q) * LINE_W + 20'(col_i_q);

  always_comb begin
    state_d        = state_q;
    col_i_d        = col_i_q;
    row_i_d        = row_i_q;
    wr_d           = 1'b0;
    addr_d         = addr_q;
    din_d          = din_q;
    write_finish_d = 1'b0;
    frame_error_d  = frame_error_q;

    case (state_q)
      W_DONE: begin
        // Frame is owned by the readout side; every input pixel is dropped.
        write_finish_d = 1'b1;
        if (read_finish) begin
          state_d        = W_IDLE;
          write_finish_d = 1'b0;
        end
      end
      W_IDLE, W_ERR, W_WRITE: begin
        if (sof) begin
          // A start-of-frame inside an unfinished frame restarts it but flags the loss.
          wr_d          = 1'b1;
          addr_d        = 20'd0;
          din_d         = in_pixel_data;
          col_i_d       = 9'd1;
          row_i_d       = 9'd0;
          state_d       = W_WRITE;
          frame_error_d = (state_q == W_WRITE) && !at_origin;
        end else if (in_pixel_valid && (state_q == W_WRITE)) begin
          wr_d   = 1'b1;
          addr_d = pix_addr;
          din_d  = in_pixel_data;
          if (at_last_col) begin
            col_i_d = 9'd0;
            row_i_d = row_i_q + 9'd1;
          end else begin
            col_i_d = col_i_q + 9'd1;
          end
          if (line_end_bad) begin
            frame_error_d = 1'b1;
            state_d       = W_ERR;
          end else if (at_last_col && (row_i_q == ROW_LAST)) begin
            state_d        = W_DONE;
            write_finish_d = 1'b1;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= W_IDLE;
      col_i_q        <= 9'd0;
      row_i_q        <= 9'd0;
      wr_q           <= 1'b0;
      addr_q         <= 20'd0;
      din_q          <= 24'd0;
      write_finish_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_i_q        <= col_i_d;
      row_i_q        <= row_i_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      write_finish_q <= write_finish_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign SRAM_EN_w    = wr_q;
  assign SRAM_WE_w    = wr_q;
  assign SRAM_Addr_w  = addr_q;
  assign SRAM_Din     = din_q;
  assign write_finish = write_finish_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_frame_write_controller.sv
// Bench for frame_write_controller (4x4 frame): vector table for a clean frame,
// directed framing corner cases, then random traffic against a pixel-index model.
module tb_frame_write_controller;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic        Clk_in = 1'b0;
  logic        Reset_n;
  logic        in_pixel_ready, in_pixel_valid, in_line_end, read_finish;
  logic [23:0] in_pixel_data;
  logic        SRAM_EN_w, SRAM_WE_w, write_finish, frame_error;
  logic [19:0] SRAM_Addr_w;
  logic [23:0] SRAM_Din;

  frame_write_controller #(.W(W), .H(H)) dut (
    .Clk_in        (Clk_in),
    .Reset_n       (Reset_n),
    .in_pixel_ready(in_pixel_ready),
    .in_pixel_valid(in_pixel_valid),
    .in_line_end   (in_line_end),
    .in_pixel_data (in_pixel_data),
    .read_finish   (read_finish),
    .SRAM_EN_w     (SRAM_EN_w),
    .SRAM_WE_w     (SRAM_WE_w),
    .SRAM_Addr_w   (SRAM_Addr_w),
    .SRAM_Din      (SRAM_Din),
    .write_finish  (write_finish),
    .frame_error   (frame_error)
  );

  always #5 Clk_in = ~Clk_in;

  wire [47:0] dut_out = {SRAM_EN_w, SRAM_WE_w, SRAM_Addr_w, SRAM_Din, write_finish, frame_error};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: p = raster index of the next expected pixel.
  int          p;
  bit          inframe, done;
  logic        exp_en, exp_wf, exp_fe;
  logic [19:0] exp_addr;
  logic [23:0] exp_din;

  typedef struct {
    logic        v, r, le;
    logic [23:0] d;
    logic        rf;
    logic [47:0] exp;
  } vec_t;
  vec_t tbl[NPIX + 2];

  function automatic logic [47:0] model_vec();
    return {exp_en, exp_en, exp_addr, exp_din, exp_wf, exp_fe};
  endfunction

  task automatic model_reset();
    p = 0; inframe = 0; done = 0;
    exp_en = 0; exp_wf = 0; exp_fe = 0; exp_addr = '0; exp_din = '0;
  endtask

  task automatic model_step(input logic v, r, le, input logic [23:0] d, input logic rf);
    exp_en = 1'b0;
    if (done) begin
      if (rf) done = 0;
    end else if (v && r) begin
      exp_fe   = inframe ? 1'b1 : 1'b0;
      inframe  = 1;
      p        = 1;
      exp_en   = 1'b1;
      exp_addr = 20'd0;
      exp_din  = d;
    end else if (v && inframe) begin
      exp_en   = 1'b1;
      exp_addr = 20'(p);
      exp_din  = d;
      if (le != ((p % W) == W - 1)) begin
        exp_fe  = 1'b1;
        inframe = 0;
      end else if (p == NPIX - 1) begin
        done    = 1;
        inframe = 0;
      end else begin
        p++;
      end
    end
    exp_wf = done;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, r, le, input logic [23:0] d, input logic rf);
    in_pixel_valid = v; in_pixel_ready = r; in_line_end = le;
    in_pixel_data = d; read_finish = rf;
    @(posedge Clk_in);
    model_step(v, r, le, d, rf);
    @(negedge Clk_in);
  endtask

  task automatic drive_chk(input logic v, r, le, input logic [23:0] d, input logic rf,
                           input string name);
    drive(v, r, le, d, rf);
    check(name, dut_out, model_vec());
  endtask

  task automatic reset_mid();
    #2 Reset_n = 1'b0;
    #1 check("async_reset", dut_out, 48'd0);
    model_reset();
    @(negedge Clk_in);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    in_pixel_valid = 0; in_pixel_ready = 0; in_line_end = 0;
    in_pixel_data = '0; read_finish = 0;
    model_reset();

    for (int i = 0; i < NPIX; i++) begin
      tbl[i].v = 1'b1; tbl[i].r = 1'(i == 0); tbl[i].le = 1'(i % W == W - 1);
      tbl[i].d = 24'(i); tbl[i].rf = 1'b0;
      tbl[i].exp = {1'b1, 1'b1, 20'(i), 24'(i), 1'(i == NPIX - 1), 1'b0};
    end
    tbl[NPIX]     = '{1'b0, 1'b0, 1'b0, 24'd0, 1'b0, {2'b00, 20'd15, 24'd15, 1'b1, 1'b0}};
    tbl[NPIX + 1] = '{1'b0, 1'b0, 1'b0, 24'd0, 1'b1, {2'b00, 20'd15, 24'd15, 1'b0, 1'b0}};

    repeat (3) @(negedge Clk_in);
    check("reset_state", dut_out, 48'd0);
    Reset_n = 1'b1;
    drive_chk(0, 0, 0, 24'd0, 0, "post_reset_idle");

    // Clean frame, data = index
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].le, tbl[i].d, tbl[i].rf);
      check($sformatf("table[%0d]", i), dut_out, tbl[i].exp);
    end

    // Frame with one-cycle valid gaps
    for (int i = 0; i < NPIX; i++) begin
      drive_chk(1, 1'(i == 0), 1'(i % W == W - 1), 24'($urandom), 0, "gap_pixel");
      drive_chk(0, 0, 0, 24'($urandom), 0, "gap_idle");
    end
    check("gap_finish", 48'(write_finish), 48'd1);
    drive_chk(0, 0, 0, 24'd0, 1, "gap_read_finish");

    // Early line end at (1,2), rest of frame dropped, then restart
    for (int i = 0; i < NPIX; i++) begin
      drive_chk(1, 1'(i == 0), 1'((i % W == W - 1) || i == 6), 24'(i), 0, "lineend_err");
      if (i == 6) begin
        check("lineend_addr6", 48'(SRAM_Addr_w), 48'd6);
        check("lineend_flag", 48'(frame_error), 48'd1);
      end
    end
    check("lineend_no_tail_write", 48'(SRAM_EN_w), 48'd0);
    drive_chk(1, 1, 0, 24'hABCDEF, 0, "err_restart");
    check("err_restart_clear", {27'd0, SRAM_Addr_w, frame_error}, 48'd0);
    for (int i = 1; i < NPIX; i++)
      drive_chk(1, 0, 1'(i % W == W - 1), 24'($urandom), 0, "err_restart_frame");

    // Pixels in W_DONE are dropped, read_finish with a coincident start-of-frame
    drive_chk(1, 0, 0, 24'h111111, 0, "done_drop0");
    drive_chk(1, 1, 0, 24'h222222, 0, "done_drop1");
    drive_chk(1, 0, 1, 24'h333333, 0, "done_drop2");
    check("done_hold", {46'd0, SRAM_EN_w, write_finish}, 48'd1);
    drive_chk(1, 1, 0, 24'h444444, 1, "done_rf_sof");
    check("done_rf_fall", {46'd0, SRAM_EN_w, write_finish}, 48'd0);

    // Start-of-frame at (2,1) restarts with frame_error set
    for (int i = 0; i < 9; i++) begin
      drive_chk(1, 1'(i == 0), 1'(i % W == W - 1), 24'(i), 0, "sof_mid_pre");
      if (i == 0) check("new_frame_addr0", {27'd0, SRAM_EN_w, SRAM_Addr_w}, 48'h100000);
    end
    drive_chk(1, 1, 0, 24'h00AA00, 0, "sof_mid");
    check("sof_mid_flag", {27'd0, SRAM_Addr_w, frame_error}, 48'd1);
    for (int i = 1; i < NPIX; i++)
      drive_chk(1, 0, 1'(i % W == W - 1), 24'(i), 0, "sof_mid_post");
    check("sof_mid_done", {25'd0, SRAM_Addr_w, write_finish, frame_error}, {25'd0, 20'd15, 1'b1, 1'b1});
    drive_chk(0, 0, 0, 24'd0, 1, "sof_mid_rf");

    // Reset after seven pixels, then a clean frame
    for (int i = 0; i < 7; i++)
      drive_chk(1, 1'(i == 0), 1'(i % W == W - 1), 24'(i), 0, "pre_reset");
    reset_mid();
    for (int i = 0; i < NPIX; i++)
      drive_chk(1, 1'(i == 0), 1'(i % W == W - 1), 24'(i), 0, "post_reset_frame");
    check("post_reset_done", {25'd0, SRAM_Addr_w, write_finish, frame_error}, {25'd0, 20'd15, 1'b1, 1'b0});
    drive_chk(0, 0, 0, 24'd0, 1, "post_reset_rf");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, r, le, rf;
      v  = 1'($urandom % 4 != 0);
      r  = 1'($urandom % 20 == 0);
      le = 1'((p % W) == W - 1) ^ 1'($urandom % 25 == 0);
      rf = 1'($urandom % 8 == 0);
      drive_chk(v, r, le, 24'($urandom), rf, "random");
      if ($urandom % 500 == 0) reset_mid();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
